// File: rtl/gf2_poly_div_41.sv
// Sequential GF(2) polynomial long divider: C (N bits) / D (M bits) -> Q, R, one dividend bit per cycle.
// Optional feature: define GFDIV_ABORT_EN to add the abort input that cancels a running division.
module gf2_poly_div_41 #(
    parameter int M = 41,
    parameter int N = 81
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
`ifdef GFDIV_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] quotient,
    output logic [M-2:0] remainder
);

    localparam int DW = $clog2(M);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_c_sr;
    logic [M-2:0]   r_d;
    logic [DW-1:0]  r_deg;
    logic [M-2:0]   r_r;
    logic [N-1:0]   r_q;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;

    logic [DW-1:0]  w_deg;
    logic [M-1:0]   w_rs;
    logic           w_qb;
    logic [M-2:0]   w_rnext;
    logic           w_abort;

`ifdef GFDIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Priority encoder: the highest set divisor bit wins.
    always_comb begin
        w_deg = '0;
        for (int i = 0; i < M; i++) begin
            if (divisor[i]) begin
                w_deg = DW'(i);
            end
        end
    end

    // The remainder never reaches degree deg, so its top divisor bit is only
    // ever cancelled and the stored remainder needs M-1 bits.
    assign w_rs    = {r_r, r_c_sr[N-1]};
    assign w_qb    = w_rs[r_deg];
    assign w_rnext = w_rs[M-2:0] ^ (w_qb ? r_d : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_c_sr  <= '0;
            r_d     <= '0;
            r_deg   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_c_sr <= dividend;
                        r_d    <= divisor[M-2:0];
                        r_deg  <= w_deg;
                        r_r    <= '0;
                        r_q    <= '0;
                        if (divisor == '0) begin
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_cnt   <= CW'(N);
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (w_abort) begin
                        r_r     <= '0;
                        r_q     <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_r    <= w_rnext;
                        r_q    <= {r_q[N-2:0], w_qb};
                        r_c_sr <= r_c_sr << 1;
                        r_cnt  <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign quotient    = r_q;
    assign remainder   = r_r;

endmodule
